ramp_sequencer: RTL and testbench
=================================

Name: ramp_sequencer

Overview:
- Controller that drives the ramp generator's enable, delta and Y inputs. Issues delta pulses at a programmable period, for a programmable number of steps.
- Keeps a shadow copy of the ramp level so the ramp never wraps past 4095.
- Supports one-shot (hold final level) and continuous (clear and restart) pattern modes.
- Sits between the pattern configuration registers and the ramp generator.

Parameters:
- PERIOD_W, 16, width of cfg_period and the internal period counter.

Ports:
- clk  input  1  16 ns master clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  pulse; latch cfg_* and begin a ramp
- stop  input  1  pulse; abort and return to IDLE
- cfg_Y  input  2  step select: 00 → 0, 01 → 1, 10 → 16, 11 → 1290
- cfg_period  input  PERIOD_W  clocks between delta pulses; 0 treated as 1
- cfg_steps  input  12  delta pulses per ramp; 0 = unlimited (saturation-limited only)
- cfg_mode  input  1  0 = one-shot, 1 = continuous
- ramp_enb  output  1  to ramp enable
- delta  output  1  to ramp delta; single-cycle pulses
- Y  output  2  to ramp Y; latched cfg_Y
- level  output  12  shadow of ramp output; equals ramp out every cycle
- step_cnt  output  12  deltas issued in the current ramp
- busy  output  1  high in RUN and CLR
- done  output  1  one-cycle pulse at ramp termination

Behaviour:
- Reset values: all outputs 0; state IDLE; latched config 0.
- All outputs are registered.
- deltaY is decoded from the latched Y. level updates on the same edge as the ramp: level <= level + deltaY when delta = 1, or 0 when ramp_enb = 0.
- States:
  - IDLE: ramp_enb = 0, delta = 0.
  - RUN: ramp_enb = 1, period counting.
  - HOLD: ramp_enb = 1, delta = 0, level frozen.
  - CLR: ramp_enb = 0 for exactly one cycle.
- start in IDLE: latch cfg_Y, cfg_period (0 → 1), cfg_steps, cfg_mode. Next cycle: RUN, period counter loaded with period−1, level = 0, step_cnt = 0.
- RUN:
  - The counter decrements each cycle.
  - At counter == 0 (a delta slot), the counter reloads with period−1. The first slot is exactly cfg_period cycles after start.
  - At a delta slot, terminate if either (cfg_steps != 0 and step_cnt == cfg_steps) or (level + deltaY > 4095, computed at 13 bits).
  - Otherwise: delta = 1 that cycle and step_cnt + 1.
- Termination:
  - No delta is issued; done = 1 for one cycle.
  - cfg_mode 0 → HOLD, with level held.
  - cfg_mode 1 → CLR for one cycle (level and step_cnt cleared), then RUN with the counter reloaded. Latched config is reused, not re-sampled.
- HOLD: remains until start (→ CLR, then RUN with new latched config) or stop.
- start in RUN or HOLD: latch new config, go to CLR for one cycle, then RUN. No done pulse.
- stop: in any state, next cycle IDLE; ramp_enb = 0, delta = 0, busy = 0, level = 0.
  - stop has priority over start in the same cycle.
  - stop in IDLE has no effect.
- cfg_* changes outside a start cycle are ignored.
- cfg_Y = 00 with cfg_steps = 0: runs indefinitely, issuing deltas with level fixed at 0, until stop.
- Period 1: a delta every cycle. The saturation check uses the already-updated level, so there are no overshoots.
- Invariant: level never exceeds 4095 and never wraps.
- rst_n low at any time: asynchronous return to reset values, including mid-RUN and during CLR.

Test Plan:
- Y = 01, period = 3, steps = 5, one-shot, start at cycle 0 → delta at cycles 3, 6, 9, 12, 15; level 1…5; done at cycle 18; HOLD with level = 5, ramp_enb = 1.
- Y = 11, period = 1, steps = 0, one-shot → deltas at cycles 1, 2, 3; level 1290, 2580, 3870; done at cycle 4 (5160 > 4095 blocked); level holds 3870.
- Y = 10, period = 1, steps = 2, continuous → level 0, 16, 32; done; ramp_enb low for one cycle; level 0; sequence repeats ≥ 3 times with identical timing.
- Y = 01, period = 0, steps = 0 → 4095 back-to-back deltas; level reaches 4095; done on the next slot; no wrap to 0.
- stop asserted at step 3 of scenario 1, start pulsed in the same cycle → next cycle IDLE, ramp_enb = 0, level = 0, busy = 0, no done.
- rst_n pulled low mid-RUN (level = 32) → all outputs 0 immediately, without a clock edge; after release, IDLE until start.

Source files
------------

// File: rtl/ramp_sequencer.sv
// Ramp sequencer: paces delta pulses into the ramp generator and
// mirrors its level so the ramp never wraps past 4095.
module ramp_sequencer #(
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic [1:0]          cfg_Y,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [11:0]         cfg_steps,
   input  logic                cfg_mode,
   output logic                ramp_enb,
   output logic                delta,
   output logic [1:0]          Y,
   output logic [11:0]         level,
   output logic [11:0]         step_cnt,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, RUN, HOLD, CLR} state_t;

   state_t state, state_nx;

   logic [PERIOD_W-1:0] period_lat, period_in, cnt, cnt_nx;
   logic [11:0]         steps_lat, level_upd, level_nx, step_nx;
   logic                mode_lat;
   logic [12:0]         dy;
   logic                slot, sat, lim, term, latch;
   logic                ramp_enb_nx, delta_nx, busy_nx, done_nx;

   always_comb begin
      unique case (Y)
         2'b00:   dy = 13'd0;
         2'b01:   dy = 13'd1;
         2'b10:   dy = 13'd16;
         default: dy = 13'd1290;
      endcase
   end

   assign period_in = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;

   // Level the ramp holds after this edge; the saturation test looks
   // one step beyond it so back-to-back deltas never overshoot.
   assign level_upd = !ramp_enb ? 12'd0
                    : delta     ? level + dy[11:0]
                    :             level;

   assign sat   = ({1'b0, level_upd} + dy) > 13'd4095;
   assign lim   = (steps_lat != 12'd0) && (step_cnt == steps_lat);
   assign slot  = (state == RUN) && (cnt == '0);
   assign term  = slot && (sat || lim);
   assign latch = start && !stop && (state != CLR);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start && !stop) state_nx = RUN;
         RUN: begin
            if (stop)       state_nx = IDLE;
            else if (start) state_nx = CLR;
            else if (term)  state_nx = mode_lat ? CLR : HOLD;
         end
         HOLD: begin
            if (stop)       state_nx = IDLE;
            else if (start) state_nx = CLR;
         end
         default: state_nx = stop ? IDLE : RUN;
      endcase
   end

   always_comb begin
      ramp_enb_nx = (state_nx == RUN) || (state_nx == HOLD);
      busy_nx     = (state_nx == RUN) || (state_nx == CLR);
      delta_nx    = slot && !term && (state_nx == RUN);
      done_nx     = term && !stop && !start;
      level_nx    = (state_nx == IDLE) ? 12'd0 : level_upd;

      step_nx = step_cnt;
      if ((state_nx == IDLE) || (state_nx == CLR))
         step_nx = 12'd0;
      else if (delta_nx)
         step_nx = step_cnt + 12'd1;

      cnt_nx = cnt;
      if ((state == IDLE) && (state_nx == RUN))
         cnt_nx = period_in - PERIOD_W'(1);
      else if ((state_nx == RUN) && ((state == CLR) || slot))
         cnt_nx = period_lat - PERIOD_W'(1);
      else if (state_nx == RUN)
         cnt_nx = cnt - PERIOD_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         period_lat <= '0;
         steps_lat  <= 12'd0;
         mode_lat   <= 1'b0;
         Y          <= 2'b00;
         ramp_enb   <= 1'b0;
         delta      <= 1'b0;
         level      <= 12'd0;
         step_cnt   <= 12'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         ramp_enb <= ramp_enb_nx;
         delta    <= delta_nx;
         level    <= level_nx;
         step_cnt <= step_nx;
         busy     <= busy_nx;
         done     <= done_nx;
         if (latch) begin
            Y          <= cfg_Y;
            period_lat <= period_in;
            steps_lat  <= cfg_steps;
            mode_lat   <= cfg_mode;
         end
      end
   end

endmodule

// File: tb/tb_ramp_sequencer.sv
// Directed bench for ramp_sequencer: cycle 0 is the edge that samples
// start; outputs are checked 1 ns after each rising edge.
module tb_ramp_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  cfg_y = 2'b00;
   logic [15:0] cfg_period = 16'd0;
   logic [11:0] cfg_steps = 12'd0;
   logic        cfg_mode = 1'b0;
   logic        ramp_enb, delta, busy, done;
   logic [1:0]  y;
   logic [11:0] level, step_cnt;

   int vectors = 0;
   int miscompares = 0;
   int exp_lvl, ndelta;

   ramp_sequencer #(.PERIOD_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .cfg_Y(cfg_y), .cfg_period(cfg_period), .cfg_steps(cfg_steps),
      .cfg_mode(cfg_mode), .ramp_enb(ramp_enb), .delta(delta), .Y(y),
      .level(level), .step_cnt(step_cnt), .busy(busy), .done(done)
   );

   always #8 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [1:0] yy, input int per,
                     input int st, input logic md);
      cfg_y = yy;
      cfg_period = 16'(per);
      cfg_steps = 12'(st);
      cfg_mode = md;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_y = ~yy;
      cfg_period = 16'd7;
      cfg_steps = 12'd9;
      cfg_mode = ~md;
   endtask

   task automatic halt();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      tick();
      chk("rst_enb", 32'(ramp_enb), 0);
      chk("rst_lvl", 32'(level), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      tick();

      // one-shot, Y=01, period 3, 5 steps
      go(2'b01, 3, 5, 1'b0);
      chk("s1_c0_enb", 32'(ramp_enb), 1);
      chk("s1_c0_busy", 32'(busy), 1);
      for (int c = 1; c <= 18; c++) begin
         tick();
         exp_lvl = (c > 15) ? 5 : (c - 1) / 3;
         chk($sformatf("s1_delta_c%0d", c), 32'(delta),
             (c % 3 == 0 && c <= 15) ? 1 : 0);
         chk($sformatf("s1_done_c%0d", c), 32'(done), (c == 18) ? 1 : 0);
         chk($sformatf("s1_lvl_c%0d", c), 32'(level), exp_lvl);
      end
      tick();
      tick();
      chk("s1_hold_enb", 32'(ramp_enb), 1);
      chk("s1_hold_lvl", 32'(level), 5);
      chk("s1_hold_steps", 32'(step_cnt), 5);
      chk("s1_hold_busy", 32'(busy), 0);
      chk("s1_hold_delta", 32'(delta), 0);
      halt();
      chk("s1_stop_lvl", 32'(level), 0);

      // saturation at Y=11, period 1, unlimited
      go(2'b11, 1, 0, 1'b0);
      tick();
      chk("s2_d1", 32'(delta), 1);
      tick();
      chk("s2_l2", 32'(level), 1290);
      tick();
      chk("s2_l3", 32'(level), 2580);
      chk("s2_d3", 32'(delta), 1);
      tick();
      chk("s2_done4", 32'(done), 1);
      chk("s2_d4", 32'(delta), 0);
      chk("s2_l4", 32'(level), 3870);
      tick();
      chk("s2_l5", 32'(level), 3870);
      chk("s2_done5", 32'(done), 0);

      // restart from HOLD with new config: CLR then RUN
      go(2'b01, 2, 1, 1'b0);
      chk("h_clr_enb", 32'(ramp_enb), 0);
      chk("h_clr_busy", 32'(busy), 1);
      chk("h_clr_done", 32'(done), 0);
      tick();
      chk("h_c1_lvl", 32'(level), 0);
      chk("h_c1_enb", 32'(ramp_enb), 1);
      tick();
      tick();
      chk("h_c3_delta", 32'(delta), 1);
      tick();
      chk("h_c4_lvl", 32'(level), 1);
      tick();
      chk("h_c5_done", 32'(done), 1);
      halt();

      // continuous, Y=10, period 1, 2 steps: 4-cycle repeat
      go(2'b10, 1, 2, 1'b1);
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk($sformatf("s3_delta_c%0d", c), 32'(delta),
             (c % 4 == 1 || c % 4 == 2) ? 1 : 0);
         chk($sformatf("s3_done_c%0d", c), 32'(done), (c % 4 == 3) ? 1 : 0);
         chk($sformatf("s3_enb_c%0d", c), 32'(ramp_enb), (c % 4 == 3) ? 0 : 1);
         chk($sformatf("s3_lvl_c%0d", c), 32'(level),
             (c % 4 == 2) ? 16 : (c % 4 == 3) ? 32 : 0);
      end
      halt();

      // period 0 behaves as 1: 4095 back-to-back deltas, no wrap
      go(2'b01, 0, 0, 1'b0);
      ndelta = 0;
      for (int c = 1; c <= 4095; c++) begin
         tick();
         if (delta) ndelta++;
      end
      chk("s4_ndelta", ndelta, 4095);
      chk("s4_l4095", 32'(level), 4094);
      tick();
      chk("s4_done", 32'(done), 1);
      chk("s4_delta", 32'(delta), 0);
      chk("s4_lvl", 32'(level), 4095);
      chk("s4_steps", 32'(step_cnt), 4095);
      tick();
      chk("s4_hold_lvl", 32'(level), 4095);
      chk("s4_hold_enb", 32'(ramp_enb), 1);
      halt();

      // stop beats start at step 3
      go(2'b01, 3, 5, 1'b0);
      for (int c = 1; c <= 9; c++) tick();
      chk("s5_d9", 32'(delta), 1);
      stop = 1'b1;
      start = 1'b1;
      tick();
      stop = 1'b0;
      start = 1'b0;
      chk("s5_enb", 32'(ramp_enb), 0);
      chk("s5_lvl", 32'(level), 0);
      chk("s5_busy", 32'(busy), 0);
      chk("s5_done", 32'(done), 0);
      chk("s5_delta", 32'(delta), 0);
      tick();
      tick();
      chk("s5_idle_busy", 32'(busy), 0);
      chk("s5_idle_done", 32'(done), 0);

      // async reset mid-RUN at level 32
      go(2'b10, 1, 0, 1'b0);
      tick();
      tick();
      tick();
      chk("s6_lvl", 32'(level), 32);
      #3 rst_n = 1'b0;
      #1;
      chk("s6_rst_lvl", 32'(level), 0);
      chk("s6_rst_enb", 32'(ramp_enb), 0);
      chk("s6_rst_busy", 32'(busy), 0);
      chk("s6_rst_delta", 32'(delta), 0);
      chk("s6_rst_y", 32'(y), 0);
      chk("s6_rst_steps", 32'(step_cnt), 0);
      #2 rst_n = 1'b1;
      tick();
      tick();
      chk("s6_idle_busy", 32'(busy), 0);
      chk("s6_idle_enb", 32'(ramp_enb), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
